profile_ci_controller: RTL and testbench
========================================

# profile_ci_controller

Custom-instruction front end for the profiling unit. Owns four WIDTH-bit up-counters and their per-counter enables, and sticky overflow flags. Decodes profiling custom instructions from the processor's CI port to start, stop and clear counters, and returns either a counter snapshot or a status word. Sits between the CPU custom-instruction bus and the profiling event sources (cycle, stall, bus-idle, generic event).

## Interface
- CUSTOM_ID, 8'd12: ciN value this block responds to.
- WIDTH, 32: counter width; must be 32 or less; results are zero-extended to 32 bits.

- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ciStart  input  1  custom-instruction start strobe.
- ciCke  input  1  CI clock enable; the controller FSM advances only when this is 1.
- ciN  input  8  custom-instruction number.
- ciValueA  input  32  read selector: [2] status select, [1:0] counter index.
- ciValueB  input  32  command word: [3:0] enable set, [7:4] disable, [11:8] clear; other bits ignored.
- stall  input  1  CPU stall event.
- busIdle  input  1  bus-idle event.
- eventIn  input  1  generic event.
- ciDone  output  1  transaction complete, one-cycle pulse.
- ciResult  output  32  read data; 0 whenever ciDone=0.

## Operation
- Counter events:
  - Counter 0 increments every cycle while en[0]=1.
  - Counter 1 increments when en[1]&stall.
  - Counter 2 increments when en[2]&busIdle.
  - Counter 3 increments when en[3]&eventIn.
- Counters run independently of ciCke and of the FSM.
- Arithmetic is modulo 2^WIDTH. On a wrap from all-ones to 0 by an increment, ovf[i] is set and stays set (sticky).
- Accept condition: state IDLE & ciStart & ciCke & ciN==CUSTOM_ID. Any other ciN is ignored: no ciDone, no state change.
- On accept in cycle T:
  - The controller latches the result:
    - ciValueA[2]=0: counter[ciValueA[1:0]] value during T.
    - ciValueA[2]=1: status = {24'b0, ovf[3:0], en[3:0]}, values during T.
  - The command applies at the T edge.
- Command priority, per counter i:
  - clear[i] forces counter[i]=0 and ovf[i]=0, overriding any increment in that cycle.
  - disable[i] takes priority over enable set[i].
  - clear does not change en[i].
- FSM states:
  - IDLE: go to RESPOND on accept.
  - RESPOND: ciDone=1, ciResult=latched value. Go to IDLE when ciCke=1; hold otherwise.
- ciStart seen while in RESPOND is ignored and is not queued.
- Reset: all counters 0, en=0, ovf=0, state IDLE, ciDone=0, ciResult=0. A reset during RESPOND aborts the transaction, and no ciDone is produced.

## Timing
- Latency: the controller accepts in cycle T and asserts ciDone in T+1 (with ciCke=1 in T+1). ciDone lasts exactly one cycle when ciCke stays 1.
- Back-to-back throughput: one instruction every 2 cycles.
- en/clear take effect from T+1:
  - A counter enabled by a command at T first increments at the T+1 edge.
  - A counter disabled at T does not increment at the T edge.
- Clear at T: counter reads 0 in T+1.
- A read-and-clear in the same instruction returns the pre-clear value.
- ciResult is forced to 0 in every cycle where ciDone=0.

## Test plan
- Reset, then enable counter 0 (ciValueB=0x001) at T; read counter 0 (ciValueA=0) at T+10 -> ciDone at T+11, ciResult=9.
- Hold stall=1 for 5 cycles with en[1]=1 and stall=0 otherwise; read counter 1 -> 5. Counter 2 read with busIdle=0 -> 0.
- With en[0]=1, issue read-and-clear of counter 0 (ciValueA=0, ciValueB=0x100) when counter 0=0x20 -> ciResult=0x20; the next read, issued 1 cycle later, returns a small value (no greater than 2).
- Use WIDTH=4 with en[3]=1 and eventIn=1 for 17 cycles; read status (ciValueA=4) -> ciResult=0x88; counter 3 reads 1. Clearing counter 3 -> status reads 0x08.
- ciStart with ciN=CUSTOM_ID+1 -> no ciDone for 10 cycles. Hold ciCke=0 in RESPOND for 3 cycles -> ciDone stays 1 and ciResult is stable, then ciDone drops one cycle after ciCke=1.
- Assert reset in the RESPOND cycle with en=0xF -> next cycle ciDone=0, status read returns 0x00, all counters 0.

Source files
------------

// File: rtl/profile_ci_controller_if.sv
// ============================================================================
// Module  : profile_ci_controller_if
// Brief   : Custom-instruction bus between the CPU and the profiling controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface profile_ci_controller_if;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;

  modport master (
    output ciStart, ciCke, ciN, ciValueA, ciValueB,
    input  ciDone, ciResult
  );

  modport slave (
    input  ciStart, ciCke, ciN, ciValueA, ciValueB,
    output ciDone, ciResult
  );
endinterface

`default_nettype wire

// File: rtl/profile_ci_controller.sv
// ============================================================================
// Module  : profile_ci_controller
// Brief   : Profiling custom-instruction front end: four event counters with
//           enables, sticky overflow flags and a two-state CI handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module profile_ci_controller #(
  parameter logic [7:0] CUSTOM_ID = 8'd12,
  parameter int         WIDTH     = 32
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              stall,
  input  wire logic              busIdle,
  input  wire logic              eventIn,
  profile_ci_controller_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RESPOND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;

  logic [3:0]  r_en;
  logic [3:0]  w_ovf;
  logic [3:0]  w_evt;
  logic [3:0]  w_set;
  logic [3:0]  w_dis;
  logic [3:0]  w_clr;
  logic [31:0] w_cnt_ext [4];
  logic [31:0] w_status;
  logic [31:0] w_rd_data;
  logic [31:0] r_result;
  logic        w_unused_bits;

  assign w_set = bus.ciValueB[3:0];
  assign w_dis = bus.ciValueB[7:4];
  assign w_clr = bus.ciValueB[11:8];
  assign w_evt = {eventIn, busIdle, stall, 1'b1};
  assign w_unused_bits = ^{bus.ciValueA[31:3], bus.ciValueB[31:12]};

  // ------------------------------------------------------------------------
  // Handshake FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ciStart && bus.ciCke && (bus.ciN == CUSTOM_ID)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: begin
        if (bus.ciCke) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Enables: disable wins over set; clear leaves the enable untouched
  // ------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_en <= 4'b0000;
    end else if (w_accept) begin
      r_en <= (r_en | w_set) & ~w_dis;
    end
  end

  // ------------------------------------------------------------------------
  // Counters and sticky overflow flags
  // ------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_cnt
    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             w_inc;
    logic             w_zap;

    // A counter being disabled by this instruction must not count on this edge.
    assign w_inc = r_en[i] & w_evt[i] & ~(w_accept & w_dis[i]);
    assign w_zap = w_accept & w_clr[i];

    always_ff @(posedge clock) begin
      if (reset) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_zap) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_inc) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) begin
          r_ovf <= 1'b1;
        end
      end
    end

    assign w_ovf[i]     = r_ovf;
    assign w_cnt_ext[i] = 32'(r_cnt);
  end

  // ------------------------------------------------------------------------
  // Result capture: pre-command values are latched on accept
  // ------------------------------------------------------------------------
  assign w_status  = {24'b0, w_ovf, r_en};
  assign w_rd_data = bus.ciValueA[2] ? w_status : w_cnt_ext[bus.ciValueA[1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= 32'b0;
    end else if (w_accept) begin
      r_result <= w_rd_data;
    end
  end

  assign bus.ciDone   = (r_state == S_RESPOND);
  assign bus.ciResult = (r_state == S_RESPOND) ? r_result : 32'b0;

endmodule

`default_nettype wire

// File: tb/tb_profile_ci_controller.sv
// ============================================================================
// Module  : tb_profile_ci_controller
// Brief   : Directed self-checking bench for profile_ci_controller (WIDTH 32 and 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_profile_ci_controller;

  logic clock;
  logic reset;
  logic stall;
  logic busIdle;
  logic eventIn;

  int vectors;
  int miscompares;

  profile_ci_controller_if bus1();
  profile_ci_controller_if bus2();

  profile_ci_controller #(.CUSTOM_ID(8'd12), .WIDTH(32)) dut32 (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .busIdle (busIdle),
    .eventIn (eventIn),
    .bus     (bus1)
  );

  profile_ci_controller #(.CUSTOM_ID(8'd12), .WIDTH(4)) dut4 (
    .clock   (clock),
    .reset   (reset),
    .stall   (stall),
    .busIdle (busIdle),
    .eventIn (eventIn),
    .bus     (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one instruction in the current cycle, sample the response cycle,
  // and return one cycle later with the controller back in IDLE.
  task automatic do_ci(input bit sel, input logic [7:0] n, input logic [31:0] a,
                       input logic [31:0] b, output logic done, output logic [31:0] res);
    if (!sel) begin
      bus1.ciStart = 1'b1; bus1.ciCke = 1'b1; bus1.ciN = n;
      bus1.ciValueA = a;   bus1.ciValueB = b;
    end else begin
      bus2.ciStart = 1'b1; bus2.ciCke = 1'b1; bus2.ciN = n;
      bus2.ciValueA = a;   bus2.ciValueB = b;
    end
    @(posedge clock); #1;
    bus1.ciStart = 1'b0; bus1.ciValueB = 32'h0;
    bus2.ciStart = 1'b0; bus2.ciValueB = 32'h0;
    done = sel ? bus2.ciDone : bus1.ciDone;
    res  = sel ? bus2.ciResult : bus1.ciResult;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    logic        d;
    logic [31:0] r;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    vectors++;
    if (bus1.ciDone !== 1'b0 || bus1.ciResult !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs32: done=%b result=%h required done=0 result=0", bus1.ciDone, bus1.ciResult);
    end
    vectors++;
    if (bus2.ciDone !== 1'b0 || bus2.ciResult !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs4: done=%b result=%h required done=0 result=0", bus2.ciDone, bus2.ciResult);
    end
    do_ci(1'b0, 8'd12, 32'h4, 32'h0, d, r);
    vectors++;
    if (d !== 1'b1 || r !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_status32: done=%b result=%h required done=1 result=0", d, r);
    end
  endtask

  task automatic test_cycle_counter();
    logic        d;
    logic [31:0] r;
    do_ci(1'b0, 8'd12, 32'h0, 32'h001, d, r);
    repeat (8) @(posedge clock);
    #1;
    do_ci(1'b0, 8'd12, 32'h0, 32'h000, d, r);
    vectors++;
    if (d !== 1'b1 || r !== 32'd9) begin
      miscompares++;
      $display("FAIL cycle_count: done=%b result=%0d required done=1 result=9", d, r);
    end
  endtask

  task automatic test_event_counters();
    logic        d;
    logic [31:0] r;
    do_ci(1'b0, 8'd12, 32'h0, 32'h006, d, r);
    stall = 1'b1;
    repeat (5) @(posedge clock);
    #1 stall = 1'b0;
    do_ci(1'b0, 8'd12, 32'h1, 32'h0, d, r);
    vectors++;
    if (r !== 32'd5) begin
      miscompares++;
      $display("FAIL stall_count: result=%0d required 5", r);
    end
    do_ci(1'b0, 8'd12, 32'h2, 32'h0, d, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL busidle_count: result=%0d required 0", r);
    end
  endtask

  task automatic test_read_clear_disable();
    logic        d;
    logic [31:0] r;
    do_ci(1'b0, 8'd12, 32'h0, 32'h101, d, r);
    repeat (31) @(posedge clock);
    #1;
    do_ci(1'b0, 8'd12, 32'h0, 32'h100, d, r);
    vectors++;
    if (r !== 32'h20) begin
      miscompares++;
      $display("FAIL read_and_clear: result=%h required 00000020", r);
    end
    do_ci(1'b0, 8'd12, 32'h0, 32'h0, d, r);
    vectors++;
    if (r !== 32'd1) begin
      miscompares++;
      $display("FAIL read_after_clear: result=%0d required 1", r);
    end
    // Counter 0 holds 3 during the disabling instruction and must freeze there.
    do_ci(1'b0, 8'd12, 32'h0, 32'h011, d, r);
    do_ci(1'b0, 8'd12, 32'h0, 32'h0, d, r);
    vectors++;
    if (r !== 32'd3) begin
      miscompares++;
      $display("FAIL disable_freeze: result=%0d required 3", r);
    end
    do_ci(1'b0, 8'd12, 32'h4, 32'h200, d, r);
    vectors++;
    if (r !== 32'h06) begin
      miscompares++;
      $display("FAIL disable_priority_status: result=%h required 00000006", r);
    end
    do_ci(1'b0, 8'd12, 32'h4, 32'h0, d, r);
    vectors++;
    if (r !== 32'h06) begin
      miscompares++;
      $display("FAIL clear_keeps_enable: result=%h required 00000006", r);
    end
  endtask

  task automatic test_overflow_width4();
    logic        d;
    logic [31:0] r;
    do_ci(1'b1, 8'd12, 32'h0, 32'h008, d, r);
    eventIn = 1'b1;
    repeat (17) @(posedge clock);
    #1 eventIn = 1'b0;
    do_ci(1'b1, 8'd12, 32'h4, 32'h0, d, r);
    vectors++;
    if (r !== 32'h88) begin
      miscompares++;
      $display("FAIL ovf_status: result=%h required 00000088", r);
    end
    do_ci(1'b1, 8'd12, 32'h3, 32'h800, d, r);
    vectors++;
    if (r !== 32'd1) begin
      miscompares++;
      $display("FAIL wrapped_count: result=%0d required 1", r);
    end
    do_ci(1'b1, 8'd12, 32'h4, 32'h0, d, r);
    vectors++;
    if (r !== 32'h08) begin
      miscompares++;
      $display("FAIL ovf_cleared_status: result=%h required 00000008", r);
    end
  endtask

  task automatic test_handshake();
    bit seen;
    seen = 1'b0;
    bus1.ciStart = 1'b1; bus1.ciCke = 1'b1; bus1.ciN = 8'd13; bus1.ciValueA = 32'h4;
    @(posedge clock); #1;
    bus1.ciStart = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus1.ciDone !== 1'b0) seen = 1'b1;
      @(posedge clock); #1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL foreign_ciN: ciDone seen=1 required 0");
    end
    // Accept a status read, then stall the response with ciCke low.
    bus1.ciStart = 1'b1; bus1.ciN = 8'd12; bus1.ciValueA = 32'h4;
    @(posedge clock); #1;
    bus1.ciStart = 1'b0; bus1.ciCke = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus1.ciDone !== 1'b1 || bus1.ciResult !== 32'h06) begin
        miscompares++;
        $display("FAIL cke_hold[%0d]: done=%b result=%h required done=1 result=00000006", k, bus1.ciDone, bus1.ciResult);
      end
      @(posedge clock); #1;
    end
    bus1.ciCke = 1'b1; bus1.ciStart = 1'b1;
    vectors++;
    if (bus1.ciDone !== 1'b1 || bus1.ciResult !== 32'h06) begin
      miscompares++;
      $display("FAIL cke_release: done=%b result=%h required done=1 result=00000006", bus1.ciDone, bus1.ciResult);
    end
    @(posedge clock); #1;
    bus1.ciStart = 1'b0;
    vectors++;
    if (bus1.ciDone !== 1'b0 || bus1.ciResult !== 32'h0) begin
      miscompares++;
      $display("FAIL done_drop: done=%b result=%h required done=0 result=0", bus1.ciDone, bus1.ciResult);
    end
    @(posedge clock); #1;
    vectors++;
    if (bus1.ciDone !== 1'b0) begin
      miscompares++;
      $display("FAIL start_not_queued: done=%b required 0", bus1.ciDone);
    end
  endtask

  task automatic test_reset_in_respond();
    logic        d;
    logic [31:0] r;
    do_ci(1'b0, 8'd12, 32'h0, 32'h00F, d, r);
    bus1.ciStart = 1'b1; bus1.ciCke = 1'b1; bus1.ciN = 8'd12; bus1.ciValueA = 32'h0;
    @(posedge clock); #1;
    bus1.ciStart = 1'b0;
    vectors++;
    if (bus1.ciDone !== 1'b1) begin
      miscompares++;
      $display("FAIL respond_before_reset: done=%b required 1", bus1.ciDone);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    vectors++;
    if (bus1.ciDone !== 1'b0 || bus1.ciResult !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_abort: done=%b result=%h required done=0 result=0", bus1.ciDone, bus1.ciResult);
    end
    stall = 1'b1; busIdle = 1'b1; eventIn = 1'b1;
    do_ci(1'b0, 8'd12, 32'h4, 32'h0, d, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_status: result=%h required 0", r);
    end
    for (int k = 0; k < 4; k++) begin
      do_ci(1'b0, 8'd12, 32'(k), 32'h0, d, r);
      vectors++;
      if (d !== 1'b1 || r !== 32'h0) begin
        miscompares++;
        $display("FAIL post_reset_cnt[%0d]: done=%b result=%h required done=1 result=0", k, d, r);
      end
    end
    stall = 1'b0; busIdle = 1'b0; eventIn = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    busIdle = 1'b0;
    eventIn = 1'b0;
    bus1.ciStart = 1'b0; bus1.ciCke = 1'b1; bus1.ciN = 8'd0;
    bus1.ciValueA = 32'h0; bus1.ciValueB = 32'h0;
    bus2.ciStart = 1'b0; bus2.ciCke = 1'b1; bus2.ciN = 8'd0;
    bus2.ciValueA = 32'h0; bus2.ciValueB = 32'h0;

    test_reset();
    test_cycle_counter();
    test_event_counters();
    test_read_clear_disable();
    test_overflow_width4();
    test_handshake();
    test_reset_in_respond();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
